// File: rtl/cred_vault_ctrl.sv
// Credential vault controller: a CAM of {account, encrypted password} records, booted from flash,
// serving lookup / enroll / update / delete requests through an external cipher core.
module cred_vault_ctrl #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [1:0]            op,
  input  logic [DATA_W-1:0]     account,
  input  logic [DATA_W-1:0]     password,
  input  logic [ADDR_W:0]       max_address,
  input  logic [2*DATA_W-1:0]   flash_rd_data,
  output logic [ADDR_W-1:0]     flash_addr,
  output logic                  flash_rd,
  output logic                  flash_wr,
  output logic [2*DATA_W-1:0]   write_data_flash,
  output logic                  cipher_start,
  output logic [DATA_W-1:0]     cipher_din,
  input  logic                  cipher_done,
  input  logic [DATA_W-1:0]     cipher_dout,
  output logic [DATA_W-1:0]     password_enc,
  output logic [1:0]            status,
  output logic                  done,
  output logic                  boot_done_signal
);

  typedef enum logic [2:0] {
    BOOT_RD, BOOT_LD, IDLE, SEARCH, ENC_REQ, ENC_WAIT, WRITE, DONE
  } state_t;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_ENROLL = 2'b01;
  localparam logic [1:0] OP_UPDATE = 2'b10;
  localparam logic [1:0] OP_DELETE = 2'b11;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_NFOUND = 2'b01;
  localparam logic [1:0] ST_FULL   = 2'b10;
  localparam logic [1:0] ST_EXISTS = 2'b11;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic                boot_arm_q;
  logic [ADDR_W:0]     boot_idx_q, boot_idx_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   acct_q, acct_d;
  logic [DATA_W-1:0]   pass_q, pass_d;
  logic [DATA_W-1:0]   enc_q, enc_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic [DATA_W-1:0]   penc_q, penc_d;
  logic [1:0]          status_q, status_d;
  logic                boot_done_q, boot_done_d;
  logic [DEPTH-1:0]    valid_q, valid_d;

  logic [DATA_W-1:0]   cam_acct_q [DEPTH];
  logic [DATA_W-1:0]   cam_enc_q  [DEPTH];

  logic                cam_we;
  logic                cam_wvalid;
  logic [ADDR_W-1:0]   cam_widx;
  logic [DATA_W-1:0]   cam_wacct;
  logic [DATA_W-1:0]   cam_wenc;

  logic                hit;
  logic                free_ok;
  logic [ADDR_W-1:0]   hit_idx;
  logic [ADDR_W-1:0]   free_idx;
  logic [ADDR_W:0]     load_cnt;

  assign load_cnt = (max_address > DEPTH_C) ? DEPTH_C : max_address;

  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (cam_acct_q[i] == acct_q)) begin
        hit     = 1'b1;
        hit_idx = ADDR_W'(i);
      end
      if (!valid_q[i]) begin
        free_ok  = 1'b1;
        free_idx = ADDR_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    boot_idx_d  = boot_idx_q;
    op_d        = op_q;
    acct_d      = acct_q;
    pass_d      = pass_q;
    enc_d       = enc_q;
    tgt_d       = tgt_q;
    penc_d      = penc_q;
    status_d    = status_q;
    boot_done_d = boot_done_q;
    valid_d     = valid_q;
    cam_we      = 1'b0;
    cam_wvalid  = 1'b1;
    cam_widx    = tgt_q;
    cam_wacct   = acct_q;
    cam_wenc    = enc_q;

    case (state_q)
      // The first cycle after reset only arms the read strobe, so no read leaks out during reset.
      BOOT_RD: begin
        if (boot_idx_q >= load_cnt) begin
          state_d     = IDLE;
          boot_done_d = 1'b1;
        end else if (boot_arm_q) begin
          state_d = BOOT_LD;
        end
      end
      BOOT_LD: begin
        cam_we     = 1'b1;
        cam_widx   = boot_idx_q[ADDR_W-1:0];
        cam_wacct  = flash_rd_data[2*DATA_W-1:DATA_W];
        cam_wenc   = flash_rd_data[DATA_W-1:0];
        cam_wvalid = |flash_rd_data[2*DATA_W-1:DATA_W];
        boot_idx_d = boot_idx_q + 1'b1;
        state_d    = BOOT_RD;
      end
      IDLE: begin
        if (go) begin
          op_d    = op;
          acct_d  = account;
          pass_d  = password;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        state_d = DONE;
        case (op_q)
          OP_LOOKUP: begin
            penc_d   = hit ? cam_enc_q[hit_idx] : '0;
            status_d = hit ? ST_OK : ST_NFOUND;
          end
          OP_ENROLL: begin
            if (hit) begin
              status_d = ST_EXISTS;
            end else if (!free_ok) begin
              status_d = ST_FULL;
            end else begin
              tgt_d   = free_idx;
              state_d = ENC_REQ;
            end
          end
          OP_UPDATE: begin
            if (hit) begin
              tgt_d   = hit_idx;
              state_d = ENC_REQ;
            end else begin
              status_d = ST_NFOUND;
            end
          end
          default: begin
            if (hit) begin
              tgt_d   = hit_idx;
              state_d = WRITE;
            end else begin
              status_d = ST_NFOUND;
            end
          end
        endcase
      end
      ENC_REQ: state_d = ENC_WAIT;
      ENC_WAIT: begin
        if (cipher_done) begin
          enc_d   = cipher_dout;
          state_d = WRITE;
        end
      end
      WRITE: begin
        cam_we     = 1'b1;
        cam_widx   = tgt_q;
        cam_wvalid = (op_q != OP_DELETE);
        status_d   = ST_OK;
        state_d    = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (cam_we) valid_d[cam_widx] = cam_wvalid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BOOT_RD;
      boot_arm_q  <= 1'b0;
      boot_idx_q  <= '0;
      op_q        <= '0;
      acct_q      <= '0;
      pass_q      <= '0;
      enc_q       <= '0;
      tgt_q       <= '0;
      penc_q      <= '0;
      status_q    <= ST_OK;
      boot_done_q <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      boot_arm_q  <= 1'b1;
      boot_idx_q  <= boot_idx_d;
      op_q        <= op_d;
      acct_q      <= acct_d;
      pass_q      <= pass_d;
      enc_q       <= enc_d;
      tgt_q       <= tgt_d;
      penc_q      <= penc_d;
      status_q    <= status_d;
      boot_done_q <= boot_done_d;
      valid_q     <= valid_d;
    end
  end

  // Record payload needs no reset: an entry is only meaningful while its valid bit is set.
  always_ff @(posedge clk) begin
    if (cam_we && cam_wvalid) begin
      cam_acct_q[cam_widx] <= cam_wacct;
      cam_enc_q[cam_widx]  <= cam_wenc;
    end
  end

  assign flash_rd         = (state_q == BOOT_RD) && boot_arm_q && (boot_idx_q < load_cnt);
  assign flash_wr         = (state_q == WRITE);
  assign cipher_start     = (state_q == ENC_REQ);
  assign done             = (state_q == DONE);
  assign flash_addr       = ((state_q == BOOT_RD) || (state_q == BOOT_LD)) ?
                            boot_idx_q[ADDR_W-1:0] : tgt_q;
  assign write_data_flash = ((state_q == WRITE) && (op_q != OP_DELETE)) ? {acct_q, enc_q} : '0;
  assign cipher_din       = pass_q;
  assign password_enc     = penc_q;
  assign status           = status_q;
  assign boot_done_signal = boot_done_q;

endmodule

// File: tb/tb_cred_vault_ctrl.sv
// Bench for cred_vault_ctrl: directed boot/op scenarios plus random ops against a record-level model.
module tb_cred_vault_ctrl;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int AW = 2;

  localparam logic [DW-1:0] ACC_A = 32'h0000_A11A;
  localparam logic [DW-1:0] ACC_B = 32'h0000_B22B;
  localparam logic [DW-1:0] ACC_C = 32'h0000_C33C;
  localparam logic [DW-1:0] ACC_D = 32'h0000_D44D;
  localparam logic [DW-1:0] ACC_E = 32'h0000_E55E;
  localparam logic [DW-1:0] ACC_F = 32'h0000_F66F;
  localparam logic [DW-1:0] ACC_Z = 32'h0000_0777;
  localparam logic [DW-1:0] ENC_A = 32'h1234_5678;
  localparam logic [DW-1:0] ENC_B = 32'h9ABC_DEF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              go = 1'b0;
  logic [1:0]        op = 2'b00;
  logic [DW-1:0]     account = '0;
  logic [DW-1:0]     password = '0;
  logic [AW:0]       max_address = 3'd3;
  logic [2*DW-1:0]   flash_rd_data = '0;
  logic [AW-1:0]     flash_addr;
  logic              flash_rd, flash_wr;
  logic [2*DW-1:0]   write_data_flash;
  logic              cipher_start;
  logic [DW-1:0]     cipher_din;
  logic              cipher_done;
  logic [DW-1:0]     cipher_dout;
  logic [DW-1:0]     password_enc;
  logic [1:0]        status;
  logic              done, boot_done_signal;

  cred_vault_ctrl #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .go(go), .op(op), .account(account), .password(password),
    .max_address(max_address), .flash_rd_data(flash_rd_data), .flash_addr(flash_addr),
    .flash_rd(flash_rd), .flash_wr(flash_wr), .write_data_flash(write_data_flash),
    .cipher_start(cipher_start), .cipher_din(cipher_din), .cipher_done(cipher_done),
    .cipher_dout(cipher_dout), .password_enc(password_enc), .status(status),
    .done(done), .boot_done_signal(boot_done_signal)
  );

  function automatic logic [DW-1:0] enc_fn(input logic [DW-1:0] p);
    return {p[15:0], p[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // Flash device
  logic [2*DW-1:0] flash_mem [DP] = '{{ACC_A, ENC_A}, {ACC_B, ENC_B}, 64'h0, 64'h0};
  always @(posedge clk) begin
    if (flash_rd) flash_rd_data <= flash_mem[flash_addr];
    if (flash_wr) flash_mem[flash_addr] <= write_data_flash;
  end

  // Cipher core with programmable response delay
  int cipher_delay = 1;
  logic [DW-1:0] din_s;
  initial begin
    cipher_done = 1'b0;
    cipher_dout = '0;
    forever begin
      @(negedge clk);
      if (cipher_start === 1'b1) begin
        din_s = cipher_din;
        repeat (cipher_delay) @(posedge clk);
        #1;
        cipher_dout = enc_fn(din_s);
        cipher_done = 1'b1;
        @(posedge clk);
        #1;
        cipher_done = 1'b0;
      end
    end
  end

  // Strobe monitor
  int rd_cnt = 0, wr_cnt = 0, start_cnt = 0, excl_bad = 0;
  logic [AW-1:0]   rd_addrs [$];
  logic [AW-1:0]   last_wr_addr = '0;
  logic [2*DW-1:0] last_wr_data = '0;
  always @(negedge clk) begin
    if (flash_rd === 1'b1) begin
      rd_cnt <= rd_cnt + 1;
      rd_addrs.push_back(flash_addr);
    end
    if (flash_wr === 1'b1) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= flash_addr;
      last_wr_data <= write_data_flash;
    end
    if (cipher_start === 1'b1) start_cnt <= start_cnt + 1;
    if ((int'(flash_rd) + int'(flash_wr) + int'(cipher_start) + int'(done)) > 1)
      excl_bad <= excl_bad + 1;
  end

  // Reference model: record table, persisted flash image, last lookup result
  logic [DW-1:0]   ref_acct  [DP];
  logic [DW-1:0]   ref_enc   [DP];
  bit              ref_valid [DP];
  logic [2*DW-1:0] ref_flash [DP] = '{{ACC_A, ENC_A}, {ACC_B, ENC_B}, 64'h0, 64'h0};
  logic [DW-1:0]   exp_penc = '0;

  int n_tot = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_boot(input int cnt);
    for (int i = 0; i < DP; i++) begin
      ref_acct[i]  = ref_flash[i][2*DW-1:DW];
      ref_enc[i]   = ref_flash[i][DW-1:0];
      ref_valid[i] = (i < cnt) && (ref_flash[i][2*DW-1:DW] != '0);
    end
    exp_penc = '0;
  endtask

  task automatic model_op(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] p,
                          input int d, output logic [1:0] st, output int lat, output bit wr,
                          output logic [AW-1:0] waddr, output logic [2*DW-1:0] wdata,
                          output bit starts);
    int h, f;
    h = -1; f = -1;
    for (int i = DP - 1; i >= 0; i--) begin
      if (ref_valid[i] && ref_acct[i] == a) h = i;
      if (!ref_valid[i]) f = i;
    end
    st = 2'b01; lat = 2; wr = 0; starts = 0; waddr = '0; wdata = '0;
    case (o)
      2'b00: begin
        st       = (h >= 0) ? 2'b00 : 2'b01;
        exp_penc = (h >= 0) ? ref_enc[h] : '0;
      end
      2'b01: begin
        if (h >= 0) st = 2'b11;
        else if (f < 0) st = 2'b10;
        else begin
          st = 2'b00; lat = 4 + d; wr = 1; starts = 1;
          waddr = AW'(f); wdata = {a, enc_fn(p)};
          ref_valid[f] = 1; ref_acct[f] = a; ref_enc[f] = enc_fn(p);
          ref_flash[f] = wdata;
        end
      end
      2'b10: begin
        if (h >= 0) begin
          st = 2'b00; lat = 4 + d; wr = 1; starts = 1;
          waddr = AW'(h); wdata = {a, enc_fn(p)};
          ref_enc[h] = enc_fn(p);
          ref_flash[h] = wdata;
        end
      end
      default: begin
        if (h >= 0) begin
          st = 2'b00; lat = 3; wr = 1;
          waddr = AW'(h); wdata = '0;
          ref_valid[h] = 0;
          ref_flash[h] = '0;
        end
      end
    endcase
  endtask

  task automatic do_op(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] p,
                       input int d, input string tag);
    logic [1:0] est;
    int elat, lat, wr0, st0;
    bit ewr, estart;
    logic [AW-1:0] ewa;
    logic [2*DW-1:0] ewd;
    model_op(o, a, p, d, est, elat, ewr, ewa, ewd, estart);
    cipher_delay = d;
    wr0 = wr_cnt;
    st0 = start_cnt;
    @(negedge clk);
    go = 1'b1; op = o; account = a; password = p;
    @(posedge clk);
    #1;
    go = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    chk({tag, ".status"}, 64'(status), 64'(est));
    chk({tag, ".password_enc"}, 64'(password_enc), 64'(exp_penc));
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    chk({tag, ".n_flash_wr"}, 64'(wr_cnt - wr0), 64'(ewr));
    chk({tag, ".n_cipher_start"}, 64'(start_cnt - st0), 64'(estart));
    if (ewr) begin
      chk({tag, ".wr_addr"}, 64'(last_wr_addr), 64'(ewa));
      chk({tag, ".wr_data"}, last_wr_data, ewd);
    end
  endtask

  task automatic wait_boot(input int exp_n, input int rd_base, input string tag);
    int n;
    n = 0;
    while (boot_done_signal !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".boot_done"}, 64'(boot_done_signal), 64'd1);
    chk({tag, ".n_flash_rd"}, 64'(rd_cnt - rd_base), 64'(exp_n));
    for (int i = 0; i < exp_n; i++)
      if (rd_base + i < rd_addrs.size())
        chk($sformatf("%s.rd_addr%0d", tag, i), 64'(rd_addrs[rd_base + i]), 64'(i));
  endtask

  logic [DW-1:0] pool [7] = '{ACC_A, ACC_B, ACC_C, ACC_D, ACC_E, ACC_F, ACC_Z};

  initial begin
    int rd0, wr0, st0;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.password_enc", 64'(password_enc), 64'd0);
    chk("rst.status", 64'(status), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.boot_done", 64'(boot_done_signal), 64'd0);
    chk("rst.flash_rd", 64'(flash_rd), 64'd0);
    chk("rst.flash_wr", 64'(flash_wr), 64'd0);
    chk("rst.cipher_start", 64'(cipher_start), 64'd0);
    chk("rst.flash_addr", 64'(flash_addr), 64'd0);

    rd0 = rd_cnt;
    @(negedge clk);
    rst = 1'b1;
    wait_boot(3, rd0, "boot3");
    model_boot(3);

    do_op(2'b00, ACC_B, 32'h0, 1, "lookupB");
    do_op(2'b00, ACC_C, 32'h0, 1, "lookupC_miss");
    do_op(2'b00, ACC_A, 32'h0, 1, "lookupA");
    do_op(2'b10, ACC_A, 32'hCAFE_0001, 3, "updateA");
    do_op(2'b00, ACC_A, 32'h0, 1, "lookupA_new");
    do_op(2'b10, ACC_Z, 32'hCAFE_0002, 2, "update_absent");
    do_op(2'b01, ACC_C, 32'hBEEF_0003, 5, "enrollC");
    do_op(2'b01, ACC_C, 32'hBEEF_0004, 5, "enrollC_again");
    do_op(2'b01, ACC_D, 32'hBEEF_0005, 2, "enrollD");
    do_op(2'b01, ACC_E, 32'hBEEF_0006, 2, "enrollE_full");
    do_op(2'b11, ACC_A, 32'h0, 1, "deleteA");
    do_op(2'b01, ACC_E, 32'hBEEF_0006, 1, "enrollE_slot0");
    do_op(2'b00, ACC_E, 32'h0, 1, "lookupE");
    do_op(2'b11, ACC_Z, 32'h0, 1, "delete_absent");

    // Reset while the controller waits on the cipher core
    cipher_delay = 20;
    st0 = start_cnt;
    @(negedge clk);
    go = 1'b1; op = 2'b10; account = ACC_B; password = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst.cipher_started", 64'(start_cnt - st0), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst.password_enc", 64'(password_enc), 64'd0);
    chk("midrst.status", 64'(status), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    chk("midrst.boot_done", 64'(boot_done_signal), 64'd0);
    chk("midrst.flash_wr", 64'(flash_wr), 64'd0);
    chk("midrst.flash_rd", 64'(flash_rd), 64'd0);
    chk("midrst.flash_addr", 64'(flash_addr), 64'd0);
    max_address = 3'd0;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("boot0.boot_done_first_cycle", 64'(boot_done_signal), 64'd1);
    model_boot(0);
    repeat (30) @(posedge clk);
    #1;
    chk("boot0.no_flash_rd", 64'(rd_cnt - rd0), 64'd0);
    chk("late_cipher_done.no_write", 64'(wr_cnt - wr0), 64'd0);
    do_op(2'b00, ACC_B, 32'h0, 1, "boot0.lookupB");

    // Reboot with a count above DEPTH: load clamps to DEPTH records from persisted flash
    max_address = 3'd7;
    rd0 = rd_cnt;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wait_boot(DP, rd0, "boot7");
    model_boot(DP);
    do_op(2'b00, ACC_C, 32'h0, 1, "boot7.lookupC");

    for (int k = 0; k < 40; k++) begin
      do_op(2'($urandom_range(0, 3)), pool[$urandom_range(0, 6)], $urandom,
            int'($urandom_range(1, 4)), $sformatf("rnd%0d", k));
    end

    chk("strobes_exclusive", 64'(excl_bad), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/cred_vault_ctrl.md
CRED_VAULT_CTRL -- requirements
Module: cred_vault_ctrl

Interface
REQ-001 Parameter DATA_W, default 128: width of the account, password and encrypted-password fields.
REQ-002 Parameter DEPTH, default 16: number of CAM entries; legal range 2..256.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): entry and flash address width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 go  in  1  operation request, sampled only in IDLE.
REQ-007 op  in  2  operation: 00 lookup, 01 enroll, 10 update, 11 delete; sampled with go.
REQ-008 account  in  DATA_W  account key; sampled with go.
REQ-009 password  in  DATA_W  plaintext password; sampled with go.
REQ-010 max_address  in  ADDR_W+1  number of flash records to load at boot.
REQ-011 flash_rd_data  in  2*DATA_W  flash read data {account, enc_pass}; valid one cycle after flash_rd.
REQ-012 flash_addr  out  ADDR_W  flash address for reads and writes.
REQ-013 flash_rd, flash_wr  out  1 each  one-cycle read and write strobes.
REQ-014 write_data_flash  out  2*DATA_W  flash write data {account, enc_pass}.
REQ-015 cipher_start  out  1; cipher_din  out  DATA_W; cipher_done  in  1; cipher_dout  in  DATA_W  external encryption core handshake.
REQ-016 password_enc  out  DATA_W  lookup result.
REQ-017 status  out  2  00 OK, 01 NOT_FOUND, 10 FULL, 11 EXISTS.
REQ-018 done  out  1; boot_done_signal  out  1.

Function
REQ-019 States: BOOT_RD, BOOT_LD, IDLE, SEARCH, ENC_REQ, ENC_WAIT, WRITE, DONE.
REQ-020 Boot: load count = min(max_address, DEPTH); for i = 0..count-1, BOOT_RD pulses flash_rd with flash_addr=i, and BOOT_LD writes CAM[i] from flash_rd_data one cycle later.
REQ-021 A loaded record whose account field is all zeros is marked invalid; entries at index >= count are invalid.
REQ-022 A count of 0 moves the FSM directly to IDLE on the first cycle after reset release.
REQ-023 boot_done_signal rises on entry to IDLE after boot and stays high until reset.
REQ-024 go is ignored outside IDLE, including during boot and busy states.
REQ-025 SEARCH compares the latched account against all valid entries in one cycle and produces hit, hit_idx (lowest matching index) and free_idx (lowest invalid index).
REQ-026 Lookup: a hit sets password_enc = CAM[hit_idx].enc with status OK; a miss sets password_enc = 0 with status NOT_FOUND.
REQ-027 Enroll: a hit gives EXISTS with no write; a miss with no free entry gives FULL; otherwise encrypt, then write free_idx.
REQ-028 Update: a hit encrypts and overwrites hit_idx; a miss gives NOT_FOUND.
REQ-029 Delete: a hit invalidates hit_idx and issues a flash write of all zeros at hit_idx; a miss gives NOT_FOUND.
REQ-030 ENC_REQ drives a one-cycle cipher_start with cipher_din = latched password; ENC_WAIT holds, unbounded, until cipher_done=1 and then captures cipher_dout.
REQ-031 cipher_done outside ENC_WAIT is ignored.
REQ-032 WRITE updates the CAM entry and pulses flash_wr for one cycle with flash_addr = target index and write_data_flash = {account, cipher_dout}; the new entry is visible to the next SEARCH.
REQ-033 DONE pulses done for one cycle, then returns to IDLE; password_enc and status hold until the next accepted go.
REQ-034 Lookup latency: done asserts exactly 2 cycles after the go sample edge (SEARCH, DONE).
REQ-035 Enroll and update latency: 4 + N cycles, where N = cipher wait cycles.
REQ-036 Delete latency: 3 cycles.
REQ-037 flash_rd, flash_wr, cipher_start and done are never asserted simultaneously.

Reset
REQ-038 rst=0 asynchronously clears all CAM valid bits, outputs and latches; password_enc=0, status=00, done=0, boot_done_signal=0, strobes=0, flash_addr=0, state=BOOT_RD.
REQ-039 On rst release, boot restarts from address 0, including when reset is asserted mid-operation or mid-cipher wait; a pending cipher_done is discarded.

Verification
REQ-040 Boot with max_address=3 and flash records A,B,0 -> three flash_rd pulses at addresses 0,1,2; boot_done_signal high; entries 0,1 valid and entry 2 invalid.
REQ-041 Lookup of B after REQ-040 -> done 2 cycles after go, status=00, password_enc=stored B enc; lookup of C -> status=01, password_enc=0.
REQ-042 Enroll C with cipher_done after 5 cycles -> flash_wr at address 2 with data {C, cipher_dout}, status=00; a repeated enroll of C -> status=11 with no flash_wr.
REQ-043 Fill all DEPTH entries, then enroll a new account -> status=10 with no cipher_start; delete entry 0, then enroll -> write at address 0.
REQ-044 Update A -> overwrites index 0; a subsequent lookup returns the new enc; update of an absent account -> status=01.
REQ-045 Assert rst during ENC_WAIT -> outputs cleared immediately; after release, boot reruns and a late cipher_done causes no write.
